fma_sequencer: RTL and testbench

Program sequencer for the BFLOAT16 FMA datapath. Drives the 4-bit address of the 16-entry × 50-bit instruction memory and decodes each fetched word. It issues FMA operations to the FMA unit over a valid/ready handshake, waits for each result and publishes it. It also handles NOP, JUMP and HALT, and stops runaway programs with a step limit.

---
 rtl/fma_sequencer_if.sv | 31 +++
 rtl/fma_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_fma_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fma_sequencer_if.sv
// Operand issue and result return link between the
// program sequencer and the bf16 FMA unit.
interface fma_sequencer_if;
   logic [15:0] fma_a;
   logic [15:0] fma_b;
   logic [15:0] fma_c;
   logic        fma_valid;
   logic        fma_ready;
   logic        fma_res_valid;
   logic [15:0] fma_res;

   modport master (
      output fma_a,
      output fma_b,
      output fma_c,
      output fma_valid,
      input  fma_ready,
      input  fma_res_valid,
      input  fma_res
   );

   modport slave (
      input  fma_a,
      input  fma_b,
      input  fma_c,
      input  fma_valid,
      output fma_ready,
      output fma_res_valid,
      output fma_res
   );
endinterface

// File: rtl/fma_sequencer.sv
// Program sequencer for the bf16 FMA datapath: fetches,
// decodes, issues FMAs and publishes each result.
module fma_sequencer #(
   parameter int ADDR_W    = 4,
   parameter int INSTR_W   = 50,
   parameter int MAX_STEPS = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               stop_i,
   output logic [ADDR_W-1:0]  pc_addr_o,
   input  logic [INSTR_W-1:0] instr_data_i,
   fma_sequencer_if.master    fma_if,
   output logic [15:0]        res_data_o,
   output logic               res_valid_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               overrun_o,
   output logic [7:0]         fma_count_o
);

   localparam int SW = $clog2(MAX_STEPS + 1);

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_FMA  = 2'b01;
   localparam logic [1:0] OP_JUMP = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [SW-1:0]      steps_q, steps_d;
   logic [15:0]        a_q, a_d;
   logic [15:0]        b_q, b_d;
   logic [15:0]        c_q, c_d;
   logic [15:0]        res_q, res_d;
   logic               resv_q, resv_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               ovr_q, ovr_d;
   logic               busy_q, busy_d;

   logic [1:0] op;
   logic       at_lim;
   logic       dec_hlt;
   logic       dec_lim;
   logic       dec_nop;
   logic       dec_fma;
   logic       dec_jmp;

   // One-hot decode; the step limit pre-empts all but HALT.
   always_comb begin
      op      = ir_q[49:48];
      at_lim  = (steps_q == SW'(MAX_STEPS));
      dec_hlt = (op == OP_HALT);
      dec_lim = at_lim && !dec_hlt;
      dec_nop = !at_lim && (op == OP_NOP);
      dec_fma = !at_lim && (op == OP_FMA);
      dec_jmp = !at_lim && (op == OP_JUMP);
   end

   // Next-state and datapath updates; stop overrides all.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      steps_d = steps_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      res_d   = res_q;
      resv_d  = 1'b0;
      cnt_d   = cnt_q;
      ovr_d   = ovr_q;
      if (stop_i) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_d = S_FETCH;
                  pc_d    = '0;
                  steps_d = '0;
                  cnt_d   = '0;
                  ovr_d   = 1'b0;
               end
            end
            S_FETCH: begin
               ir_d    = instr_data_i;
               steps_d = steps_q + 1'b1;
               state_d = S_EXEC;
            end
            S_EXEC: begin
               unique case (1'b1)
                  dec_hlt: state_d = S_DONE;
                  dec_lim: begin
                     ovr_d   = 1'b1;
                     state_d = S_DONE;
                  end
                  dec_nop: begin
                     pc_d    = pc_q + 1'b1;
                     state_d = S_FETCH;
                  end
                  dec_fma: begin
                     a_d     = ir_q[47:32];
                     b_d     = ir_q[31:16];
                     c_d     = ir_q[15:0];
                     state_d = S_ISSUE;
                  end
                  dec_jmp: begin
                     pc_d    = ir_q[ADDR_W-1:0];
                     state_d = S_FETCH;
                  end
                  default: state_d = S_DONE;
               endcase
            end
            S_ISSUE: begin
               if (fma_if.fma_ready) begin
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (fma_if.fma_res_valid) begin
                  res_d   = fma_if.fma_res;
                  resv_d  = 1'b1;
                  cnt_d   = (cnt_q == 8'hFF) ? cnt_q
                                             : cnt_q + 8'd1;
                  pc_d    = pc_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      busy_d = !((state_d == S_IDLE) ||
                 (state_d == S_DONE));
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         steps_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         res_q   <= '0;
         resv_q  <= 1'b0;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         steps_q <= steps_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         res_q   <= res_d;
         resv_q  <= resv_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
      end
   end

   assign pc_addr_o        = pc_q;
   assign fma_if.fma_a     = a_q;
   assign fma_if.fma_b     = b_q;
   assign fma_if.fma_c     = c_q;
   assign fma_if.fma_valid = (state_q == S_ISSUE);
   assign res_data_o       = res_q;
   assign res_valid_o      = resv_q;
   assign busy_o           = busy_q;
   assign done_o           = (state_q == S_DONE);
   assign overrun_o        = ovr_q;
   assign fma_count_o      = cnt_q;

endmodule

// File: tb/tb_fma_sequencer.sv
// Self-checking bench: instruction-walk model of each run
// compared cycle by cycle, plus directed corner cases.
module tb_fma_sequencer;
   localparam int MAXS = 1024;
   localparam int NQ   = 80;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [3:0]  pc_addr;
   logic [49:0] instr_data;
   logic [15:0] res_data;
   logic        res_valid;
   logic        busy;
   logic        done;
   logic        overrun;
   logic [7:0]  fma_count;
   logic [49:0] mem [16];

   fma_sequencer_if ifc();

   fma_sequencer #(
      .ADDR_W(4), .INSTR_W(50), .MAX_STEPS(64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start_i(start),
      .stop_i(stop),
      .pc_addr_o(pc_addr),
      .instr_data_i(instr_data),
      .fma_if(ifc),
      .res_data_o(res_data),
      .res_valid_o(res_valid),
      .busy_o(busy),
      .done_o(done),
      .overrun_o(overrun),
      .fma_count_o(fma_count)
   );

   always #5 clk = ~clk;
   assign instr_data = mem[pc_addr];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   // Reference model storage, indexed by cycle since start.
   int          e_fetch [MAXS];
   bit          e_busy  [MAXS];
   bit          e_valid [MAXS];
   bit          e_resv  [MAXS];
   logic [47:0] e_ops   [MAXS];
   logic [15:0] e_res   [MAXS];
   int          e_cntv  [MAXS];
   int          dslot, e_ovr, e_cnt_final, e_nfetch;
   int          rdv [NQ];
   int          sdv [NQ];
   logic [15:0] resq [NQ];

   // Walk the program instruction by instruction and lay out
   // the cycles each one occupies.
   task automatic build_model();
      int s, pc, steps, k, cnt;
      logic [49:0] ir;
      bit fin;
      for (int i = 0; i < MAXS; i++) begin
         e_fetch[i] = -1;
         e_busy[i]  = 0;
         e_valid[i] = 0;
         e_resv[i]  = 0;
         e_ops[i]   = '0;
         e_res[i]   = '0;
         e_cntv[i]  = 0;
      end
      s = 1; pc = 0; steps = 0; k = 0; cnt = 0;
      fin = 0; e_ovr = 0; e_nfetch = 0;
      while (!fin) begin
         e_fetch[s] = pc;
         e_busy[s]  = 1;
         ir = mem[pc];
         steps++;
         e_nfetch++;
         s++;
         e_busy[s] = 1;
         s++;
         if (ir[49:48] == 2'b11) fin = 1;
         else if (steps == 64) begin
            e_ovr = 1;
            fin = 1;
         end else if (ir[49:48] == 2'b00) begin
            pc = (pc + 1) % 16;
         end else if (ir[49:48] == 2'b10) begin
            pc = int'(ir[3:0]);
         end else begin
            for (int i = 0; i <= rdv[k]; i++) begin
               e_busy[s]  = 1;
               e_valid[s] = 1;
               e_ops[s]   = ir[47:0];
               s++;
            end
            for (int i = 0; i <= sdv[k]; i++) begin
               e_busy[s] = 1;
               s++;
            end
            cnt = (cnt < 255) ? cnt + 1 : 255;
            e_resv[s] = 1;
            e_res[s]  = resq[k];
            e_cntv[s] = cnt;
            k++;
            pc = (pc + 1) % 16;
         end
      end
      dslot = s;
      cnt = 0;
      for (int i = 1; i < MAXS; i++) begin
         if (e_resv[i]) cnt = e_cntv[i];
         e_cntv[i] = cnt;
      end
      e_cnt_final = cnt;
   endtask

   // FMA unit: ready after rdv cycles of valid, result after
   // sdv idle WAIT cycles, stray result strobes elsewhere.
   int u_k = 0, u_vcnt = 0, u_wcnt = 0, hs_count = 0;
   bit u_wait = 0, u_prev_hs = 0;

   always @(negedge clk) begin
      ifc.fma_ready     = 1'b0;
      ifc.fma_res_valid = 1'b0;
      ifc.fma_res       = 16'($urandom);
      if (u_prev_hs) begin
         u_wait = 1;
         u_wcnt = 0;
         u_prev_hs = 0;
      end
      if (ifc.fma_valid) begin
         if (u_vcnt >= rdv[u_k]) begin
            ifc.fma_ready = 1'b1;
            u_prev_hs = 1;
            u_vcnt = 0;
            hs_count++;
         end else u_vcnt++;
      end
      if (u_wait) begin
         if (u_wcnt >= sdv[u_k]) begin
            ifc.fma_res_valid = 1'b1;
            ifc.fma_res = resq[u_k];
            u_wait = 0;
            if (u_k < NQ - 1) u_k++;
         end else u_wcnt++;
      end else if ($urandom_range(7) == 0) begin
         ifc.fma_res_valid = 1'b1;
      end
   end

   // Cycle compare against the model while a run is active.
   bit          run_on = 0;
   int          slot = -1;
   int          resp_count = 0, resp_slot = 0;
   bit          got_ops = 0;
   logic [47:0] obs_ops = '0;

   always @(posedge clk) begin
      #3;
      if (run_on) begin
         slot++;
         if (slot >= 1 && slot < MAXS) begin
            chk("busy", busy, e_busy[slot]);
            chk("done", done, slot >= dslot);
            chk("overrun", overrun,
                (slot >= dslot) ? e_ovr : 0);
            chk("fma_valid", ifc.fma_valid, e_valid[slot]);
            if (e_valid[slot])
               chk("operands",
                   {ifc.fma_a, ifc.fma_b, ifc.fma_c},
                   e_ops[slot]);
            chk("res_valid", res_valid, e_resv[slot]);
            if (e_resv[slot])
               chk("res_data", res_data, e_res[slot]);
            chk("fma_count", fma_count, e_cntv[slot]);
            if (e_fetch[slot] >= 0)
               chk("pc_addr", pc_addr, e_fetch[slot]);
            if (res_valid) begin
               resp_count++;
               resp_slot = slot;
            end
            if (ifc.fma_valid && !got_ops) begin
               obs_ops = {ifc.fma_a, ifc.fma_b, ifc.fma_c};
               got_ops = 1;
            end
         end
      end
   end

   task automatic unit_reset();
      u_k = 0; u_vcnt = 0; u_wcnt = 0;
      u_wait = 0; u_prev_hs = 0; hs_count = 0;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) mem[i] = '0;
      for (int i = 0; i < NQ; i++) begin
         rdv[i] = 0;
         sdv[i] = 0;
         resq[i] = 16'($urandom);
      end
   endtask

   task automatic do_run();
      int t;
      build_model();
      @(posedge clk); #1;
      unit_reset();
      resp_count = 0; resp_slot = 0; got_ops = 0;
      slot = -1; run_on = 1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t = 0;
      while (slot < dslot + 2 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      #1;
      run_on = 0;
      chk("run_timeout", slot >= dslot + 2, 1);
   endtask

   localparam logic [49:0] HALT = {2'b11, 48'h0};

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_prog();
      ifc.fma_ready = 1'b0;
      ifc.fma_res_valid = 1'b0;
      ifc.fma_res = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #4;
         chk("rst_pc", pc_addr, 0);
         chk("rst_ops", {ifc.fma_a, ifc.fma_b, ifc.fma_c}, 0);
         chk("rst_valid", ifc.fma_valid, 0);
         chk("rst_res", res_data, 0);
         chk("rst_resv", res_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_ovr", overrun, 0);
         chk("rst_cnt", fma_count, 0);
      end

      clear_prog();
      mem[0] = {2'b01, 16'h4000, 16'h4040, 16'h3F80};
      mem[1] = HALT;
      sdv[0] = 1;
      resq[0] = 16'h40E0;
      build_model();
      chk("model_fma_dslot", dslot, 8);
      do_run();
      chk("fma_res", res_data, 16'h40E0);
      chk("fma_cnt", fma_count, 1);
      chk("fma_done", done, 1);
      chk("fma_ovr", overrun, 0);
      chk("fma_pulses", resp_count, 1);
      chk("fma_ops", obs_ops, 48'h4000_4040_3F80);
      chk("fma_hs", hs_count, 1);

      clear_prog();
      mem[0] = {2'b01, 16'h3F80, 16'h4000, 16'h0000};
      mem[1] = HALT;
      rdv[0] = 3;
      build_model();
      chk("model_stall_dslot", dslot, 10);
      do_run();
      chk("stall_hs", hs_count, 1);
      chk("stall_latency", resp_slot, 8);
      chk("stall_cnt", fma_count, 1);

      clear_prog();
      mem[1] = {2'b10, 48'h0};
      build_model();
      chk("model_loop_fetches", e_nfetch, 64);
      chk("model_loop_dslot", dslot, 129);
      do_run();
      chk("loop_ovr", overrun, 1);
      chk("loop_cnt", fma_count, 0);
      chk("loop_done", done, 1);

      clear_prog();
      mem[15] = {2'b10, 48'h3};
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         #3;
         chk("wrap_pc", pc_addr, i);
         chk("wrap_busy", busy, 1);
         if (i == 15) mem[3] = HALT;
         @(posedge clk);
         @(posedge clk); #1;
      end
      #3;
      chk("wrap_target", pc_addr, 3);
      @(posedge clk);
      @(posedge clk); #4;
      chk("wrap_done", done, 1);
      chk("wrap_ovr", overrun, 0);
      chk("wrap_busy_end", busy, 0);

      clear_prog();
      mem[0] = {2'b01, 16'h4000, 16'h4000, 16'h4000};
      mem[1] = HALT;
      sdv[0] = 1;
      @(posedge clk); #1;
      unit_reset();
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk); #1;
      chk("stop_wait_busy", busy, 1);
      chk("stop_wait_valid", ifc.fma_valid, 0);
      stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      #3;
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
      chk("stop_valid", ifc.fma_valid, 0);
      chk("stop_resv", res_valid, 0);
      @(posedge clk); #4;
      chk("stop_resv_late", res_valid, 0);
      chk("stop_busy_late", busy, 0);
      chk("stop_cnt", fma_count, 0);
      @(posedge clk); #1;
      start = 1'b1;
      stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      stop = 1'b0;
      #3;
      chk("ss_busy", busy, 0);
      chk("ss_done", done, 0);
      @(posedge clk); #4;
      chk("ss_busy_late", busy, 0);
      chk("ss_valid", ifc.fma_valid, 0);

      for (int r = 0; r < 40; r++) begin
         clear_prog();
         for (int a = 0; a < 16; a++) begin
            int x;
            x = $urandom_range(9);
            if (x == 9 && (r % 4) == 0) x = 5;
            mem[a] = {$urandom, $urandom};
            if (x <= 3) mem[a][49:48] = 2'b01;
            else if (x <= 6) mem[a][49:48] = 2'b00;
            else if (x <= 8) mem[a][49:48] = 2'b10;
            else mem[a][49:48] = 2'b11;
         end
         for (int i = 0; i < NQ; i++) begin
            rdv[i] = $urandom_range(3);
            sdv[i] = $urandom_range(3);
         end
         do_run();
         chk("rand_cnt", fma_count, e_cnt_final);
         chk("rand_ovr", overrun, e_ovr);
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end
endmodule
